// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler.
package frame_sched_pkg;

    localparam int unsigned TICK_CYC_DEF  = 6554;
    localparam int unsigned WDT_CYC_DEF   = 32768;
    localparam int unsigned TIMER_SEL_MAX = 300;
    localparam int unsigned SEL_W         = 9;
    localparam int unsigned MISS_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        RUN  = 2'd3
    } sched_state_e;

    // Period selection forced into [1, TIMER_SEL_MAX] ticks.
    function automatic logic [SEL_W-1:0] sel_clamp(input logic [SEL_W-1:0] sel);
        if (sel == '0) begin
            return SEL_W'(1);
        end
        if (sel > SEL_W'(TIMER_SEL_MAX)) begin
            return SEL_W'(TIMER_SEL_MAX);
        end
        return sel;
    endfunction

endpackage

// File: rtl/frame_sched_tick.sv
// Tick prescaler and period counter; expire marks the last cycle of a period.
module frame_sched_tick
    import frame_sched_pkg::*;
#(
    parameter int unsigned TICK_CYC = TICK_CYC_DEF
) (
    input  logic             clk_32k,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
    input  logic [SEL_W-1:0] sel_eff,
    output logic             expire
);

    localparam int unsigned TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [TICK_W-1:0] tick_cnt_q;
    logic [SEL_W-1:0]  per_cnt_q;
    logic              tick_wrap;
    logic              per_last;

    assign tick_wrap = (tick_cnt_q == TICK_W'(TICK_CYC - 1));
    assign per_last  = (per_cnt_q == (sel_eff - SEL_W'(1)));
    assign expire    = run && !restart && tick_wrap && per_last;

    // Counters hold while run is low so a stopped period never re-expires.
    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            per_cnt_q  <= '0;
        end else if (restart) begin
            tick_cnt_q <= '0;
            per_cnt_q  <= '0;
        end else if (run) begin
            if (tick_wrap) begin
                tick_cnt_q <= '0;
                per_cnt_q  <= per_last ? '0 : per_cnt_q + SEL_W'(1);
            end else begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_sched.sv
// Periodic frame request scheduler with miss accounting.
// Optional frame watchdog enabled by defining FRAME_SCHED_WDT_EN.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int unsigned TICK_CYC = TICK_CYC_DEF,
    parameter int unsigned WDT_CYC  = WDT_CYC_DEF
) (
    input  logic              clk_32k,
    input  logic              rst_n,
    input  logic              rg_timer_on,
    input  logic              rg_timer_mode,
    input  logic [SEL_W-1:0]  rg_timer_sel,
    input  logic              frame_ack,
    input  logic              frame_done_flag,
    input  logic              ovr_clear,
    output logic              frame_req,
    output logic              frame_on,
    output logic              timer_int,
    output logic              timer_ovr_flag,
    output logic [MISS_W-1:0] miss_cnt,
    output logic              wdt_to_flag,
    output logic [1:0]        sched_state
);

    sched_state_e     state_q;
    sched_state_e     state_d;
    logic             frame_req_d;
    logic             frame_on_d;
    logic [SEL_W-1:0] sel_eff_q;
    logic             run;
    logic             restart;
    logic             expire;
    logic             miss;
    logic             wdt_to;

    // Counters keep running through REQ/RUN only in auto mode.
    assign run     = (state_q == WAIT) ||
                     (((state_q == REQ) || (state_q == RUN)) && rg_timer_mode);
    assign restart = (state_q == IDLE) && rg_timer_on;
    assign miss    = expire && (state_q != WAIT);

    assign sched_state = state_q;

    frame_sched_tick #(
        .TICK_CYC (TICK_CYC)
    ) u_tick (
        .clk_32k  (clk_32k),
        .rst_n    (rst_n),
        .run      (run),
        .restart  (restart),
        .sel_eff  (sel_eff_q),
        .expire   (expire)
    );

    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_req <= 1'b0;
            frame_on  <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_req <= frame_req_d;
            frame_on  <= frame_on_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rg_timer_on) state_d = WAIT;
            WAIT: begin
                if (!rg_timer_on) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!rg_timer_on) begin
                    state_d = IDLE;
                end else if (frame_ack) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A running frame always completes; disable only takes effect after it.
                if (frame_done_flag || wdt_to) begin
                    state_d = (rg_timer_mode && rg_timer_on) ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_req_d = 1'b0;
        frame_on_d  = 1'b0;
        frame_req_d = (state_d == REQ);
        frame_on_d  = (state_d == RUN);
    end

    // Period bookkeeping; a miss wins over a coincident clear.
    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            timer_int      <= 1'b0;
            sel_eff_q      <= SEL_W'(1);
            miss_cnt       <= '0;
            timer_ovr_flag <= 1'b0;
        end else begin
            timer_int <= expire;
            if (restart || expire) begin
                sel_eff_q <= sel_clamp(rg_timer_sel);
            end
            if (miss) begin
                timer_ovr_flag <= 1'b1;
                if (ovr_clear) begin
                    miss_cnt <= MISS_W'(1);
                end else if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + MISS_W'(1);
                end
            end else if (ovr_clear) begin
                timer_ovr_flag <= 1'b0;
                miss_cnt       <= '0;
            end
        end
    end

`ifdef FRAME_SCHED_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);

    logic [WDT_W-1:0] wdt_cnt_q;

    assign wdt_to = (state_q == RUN) && !frame_done_flag &&
                    (wdt_cnt_q == WDT_W'(WDT_CYC - 1));

    always_ff @(posedge clk_32k or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q   <= '0;
            wdt_to_flag <= 1'b0;
        end else begin
            wdt_cnt_q <= (state_q == RUN) ? wdt_cnt_q + WDT_W'(1) : '0;
            if (wdt_to) begin
                wdt_to_flag <= 1'b1;
            end else if (ovr_clear) begin
                wdt_to_flag <= 1'b0;
            end
        end
    end
`else
    logic wdt_cyc_unused;

    assign wdt_cyc_unused = ^WDT_CYC;
    assign wdt_to         = 1'b0;
    assign wdt_to_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: period-level reference model plus directed scenarios.
module tb_frame_sched;

    localparam int unsigned TICK = 4;
    localparam int unsigned WDT  = 40;
`ifdef FRAME_SCHED_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    logic       clk_32k = 1'b0;
    logic       rst_n   = 1'b1;
    logic       on      = 1'b0;
    logic       mode    = 1'b0;
    logic [8:0] sel     = '0;
    logic       ack     = 1'b0;
    logic       done    = 1'b0;
    logic       clr     = 1'b0;

    logic       frame_req;
    logic       frame_on;
    logic       timer_int;
    logic       timer_ovr_flag;
    logic [3:0] miss_cnt;
    logic       wdt_to_flag;
    logic [1:0] sched_state;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // reference model state: elapsed cycles in the current period
    int m_state = 0, m_el = 0, m_sel = 1, m_miss = 0, m_wdt_cnt = 0, m_nst = 0;
    bit m_req = 0, m_on = 0, m_tint = 0, m_ovr = 0, m_wdt = 0;
    bit m_run = 0, m_exp = 0, m_to = 0;

    int cyc = 0;
    int tint_q[$];
    int run_starts = 0;
    bit on_prev = 0;

    frame_sched #(
        .TICK_CYC (TICK),
        .WDT_CYC  (WDT)
    ) dut (
        .clk_32k         (clk_32k),
        .rst_n           (rst_n),
        .rg_timer_on     (on),
        .rg_timer_mode   (mode),
        .rg_timer_sel    (sel),
        .frame_ack       (ack),
        .frame_done_flag (done),
        .ovr_clear       (clr),
        .frame_req       (frame_req),
        .frame_on        (frame_on),
        .timer_int       (timer_int),
        .timer_ovr_flag  (timer_ovr_flag),
        .miss_cnt        (miss_cnt),
        .wdt_to_flag     (wdt_to_flag),
        .sched_state     (sched_state)
    );

    always #5 clk_32k = ~clk_32k;

    function automatic int clamp_sel(input int s);
        if (s == 0) return 1;
        if (s > 300) return 300;
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a period is sel*TICK cycles of counting time.
    initial forever begin
        @(posedge clk_32k or negedge rst_n);
        if (!rst_n) begin
            m_state = 0; m_el = 0; m_sel = 1; m_miss = 0; m_wdt_cnt = 0;
            m_req = 0; m_on = 0; m_tint = 0; m_ovr = 0; m_wdt = 0;
        end else begin
            m_run = (m_state == 1) || (m_state >= 2 && mode);
            m_exp = m_run && (m_el == m_sel * int'(TICK) - 1);
            m_to  = WDT_EN && m_state == 3 && !done && (m_wdt_cnt == int'(WDT) - 1);
            case (m_state)
                0:       m_nst = on ? 1 : 0;
                1:       m_nst = !on ? 0 : (m_exp ? 2 : 1);
                2:       m_nst = !on ? 0 : (ack ? 3 : 2);
                default: m_nst = (done || m_to) ? ((mode && on) ? 1 : 0) : 3;
            endcase
            m_tint = m_exp;
            if (m_exp && m_state != 1) begin
                m_ovr  = 1;
                m_miss = clr ? 1 : (m_miss < 15 ? m_miss + 1 : 15);
            end else if (clr) begin
                m_ovr  = 0;
                m_miss = 0;
            end
            if (m_to) m_wdt = 1;
            else if (clr) m_wdt = 0;
            m_wdt_cnt = (m_state == 3) ? m_wdt_cnt + 1 : 0;
            if ((m_state == 0 && on) || m_exp) begin
                m_el  = 0;
                m_sel = clamp_sel(int'(sel));
            end else if (m_run) begin
                m_el = m_el + 1;
            end
            m_state = m_nst;
            m_req   = (m_nst == 2);
            m_on    = (m_nst == 3);
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk_32k);
        if (chk_en) begin
            chk("cyc_frame_req", int'(frame_req), int'(m_req));
            chk("cyc_frame_on", int'(frame_on), int'(m_on));
            chk("cyc_timer_int", int'(timer_int), int'(m_tint));
            chk("cyc_timer_ovr_flag", int'(timer_ovr_flag), int'(m_ovr));
            chk("cyc_miss_cnt", int'(miss_cnt), m_miss);
            chk("cyc_wdt_to_flag", int'(wdt_to_flag), int'(m_wdt));
            chk("cyc_sched_state", int'(sched_state), m_state);
        end
    end

    // Event log for the scenario-level literal checks.
    initial forever begin
        @(negedge clk_32k);
        cyc++;
        if (timer_int) tint_q.push_back(cyc);
        if (frame_on && !on_prev) run_starts++;
        on_prev = frame_on;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic wait_req(input int maxc);
        int n = 0;
        while (frame_req !== 1'b1 && n < maxc) begin
            @(negedge clk_32k);
            n++;
        end
        chk("wait_req", int'(frame_req), 1);
    endtask

    task automatic wait_state(input int s, input int maxc);
        int n = 0;
        while (int'(sched_state) != s && n < maxc) begin
            @(negedge clk_32k);
            n++;
        end
        chk("wait_state", int'(sched_state), s);
    endtask

    task automatic cycles_to_tint(input int maxc, output int n);
        n = 0;
        while (timer_int !== 1'b1 && n < maxc) begin
            @(negedge clk_32k);
            n++;
        end
    endtask

    // Frame engine: ack ack_dly cycles after req, done after done_dly RUN cycles.
    task automatic do_frame(input int ack_dly, input int done_dly, input bit drop_on);
        wait_req(3000);
        repeat (ack_dly) @(negedge clk_32k);
        ack = 1'b1;
        @(negedge clk_32k);
        ack = 1'b0;
        if (drop_on) on = 1'b0;
        repeat (done_dly - 1) @(negedge clk_32k);
        done = 1'b1;
        @(negedge clk_32k);
        done = 1'b0;
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk_32k);
        chk("rst_state", int'(sched_state), 0);
        chk("rst_frame_req", int'(frame_req), 0);
        chk("rst_miss_cnt", int'(miss_cnt), 0);
        #1 rst_n = 1'b1;

        // auto, sel=3: 12-cycle period, three clean frames
        @(negedge clk_32k);
        tint_q.delete(); run_starts = 0;
        mode = 1'b1; sel = 9'd3; on = 1'b1;
        repeat (3) do_frame(2, 5, 1'b0);
        on = 1'b0;
        @(negedge clk_32k);
        chk("s1_idle", int'(sched_state), 0);
        chk("s1_tint_count", tint_q.size(), 3);
        if (tint_q.size() >= 3) begin
            chk("s1_tint_gap1", tint_q[1] - tint_q[0], 12);
            chk("s1_tint_gap2", tint_q[2] - tint_q[1], 12);
        end
        chk("s1_run_count", run_starts, 3);
        chk("s1_miss_cnt", int'(miss_cnt), 0);

        // single, sel=0 -> one tick period, one frame, then idle
        @(negedge clk_32k);
        tint_q.delete(); run_starts = 0;
        mode = 1'b0; sel = 9'd0; on = 1'b1;
        wait_state(1, 10);
        cycles_to_tint(50, n);
        chk("s2_expiry_cycles", n, 4);
        do_frame(1, 3, 1'b1);
        repeat (20) @(negedge clk_32k);
        chk("s2_idle", int'(sched_state), 0);
        chk("s2_tint_count", tint_q.size(), 1);
        chk("s2_run_count", run_starts, 1);

        // auto, sel=1, long frame -> misses accumulate, then clear
        mode = 1'b1; sel = 9'd1; on = 1'b1;
        do_frame(0, 30, 1'b0);
        on = 1'b0;
        chk("s3_miss_cnt", int'(miss_cnt), 7);
        chk("s3_ovr_flag", int'(timer_ovr_flag), 1);
        @(negedge clk_32k);
        chk("s3_idle", int'(sched_state), 0);
        clr = 1'b1;
        @(negedge clk_32k);
        clr = 1'b0;
        @(negedge clk_32k);
        chk("s3_miss_cleared", int'(miss_cnt), 0);
        chk("s3_ovr_cleared", int'(timer_ovr_flag), 0);

        // sel=400 clamps to 300 ticks; disable while in REQ
        mode = 1'b0; sel = 9'd400; on = 1'b1;
        wait_state(1, 10);
        cycles_to_tint(1500, n);
        chk("s4_period", n, 1200);
        chk("s4_req_at_expiry", int'(frame_req), 1);
        on = 1'b0;
        @(negedge clk_32k);
        chk("s4_idle", int'(sched_state), 0);
        chk("s4_req_dropped", int'(frame_req), 0);

        // watchdog (if built in) and reset in the middle of a frame
        mode = 1'b0; sel = 9'd1; on = 1'b1;
        wait_req(20);
        ack = 1'b1;
        @(negedge clk_32k);
        ack = 1'b0;
`ifdef FRAME_SCHED_WDT_EN
        n = 0;
        while (sched_state == 2'd3 && n < 100) begin
            n++;
            @(negedge clk_32k);
        end
        chk("s5_wdt_run_cycles", n, 40);
        chk("s5_wdt_flag", int'(wdt_to_flag), 1);
        wait_req(20);
        ack = 1'b1;
        @(negedge clk_32k);
        ack = 1'b0;
`else
        repeat (50) @(negedge clk_32k);
        chk("s5_still_running", int'(sched_state), 3);
        chk("s5_wdt_flag_tied", int'(wdt_to_flag), 0);
`endif
        repeat (3) @(negedge clk_32k);
        chk("s5_in_run", int'(frame_on), 1);
        #1 rst_n = 1'b0;
        on = 1'b0;
        @(negedge clk_32k);
        chk("s5_rst_state", int'(sched_state), 0);
        chk("s5_rst_frame_on", int'(frame_on), 0);
        chk("s5_rst_frame_req", int'(frame_req), 0);
        chk("s5_rst_timer_int", int'(timer_int), 0);
        chk("s5_rst_ovr", int'(timer_ovr_flag), 0);
        chk("s5_rst_miss", int'(miss_cnt), 0);
        chk("s5_rst_wdt", int'(wdt_to_flag), 0);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk_32k);
        chk("s5_post_reset_idle", int'(sched_state), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter TICK_CYC, default 6554, meaning clk_32k cycles per 0.2 s tick.
REQ-002 SHALL have parameter WDT_CYC, default 32768, meaning frame watchdog limit in clk_32k cycles (1 s).
REQ-003 SHALL have port clk_32k  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rg_timer_on  input  1  scheduler enable.
REQ-006 SHALL have port rg_timer_mode  input  1  0: single; 1: auto.
REQ-007 SHALL have port rg_timer_sel  input  9  period in ticks, [1;300]x0.2 s.
REQ-008 SHALL have port frame_ack  input  1  frame engine accepts request.
REQ-009 SHALL have port frame_done_flag  input  1  1-cycle frame-complete pulse.
REQ-010 SHALL have port ovr_clear  input  1  clears sticky flags and miss_cnt.
REQ-011 SHALL have port frame_req  output  1  frame request, held until ack.
REQ-012 SHALL have port frame_on  output  1  frame in progress; drives int_ctrl frame_on.
REQ-013 SHALL have port timer_int  output  1  1-cycle pulse per period expiry.
REQ-014 SHALL have port timer_ovr_flag  output  1  sticky: period expired while not in WAIT.
REQ-015 SHALL have port miss_cnt  output  4  missed periods, saturating at 15.
REQ-016 SHALL have port wdt_to_flag  output  1  sticky watchdog timeout.
REQ-017 SHALL have port sched_state  output  2  current state encoding.

Function
REQ-018 SHALL implement states IDLE=0, WAIT=1, REQ=2, RUN=3.
REQ-019 SHALL, in IDLE with rg_timer_on=1, go to WAIT next cycle, clearing tick and period counters and latching sel_eff.
REQ-020 SHALL compute sel_eff = 1 if rg_timer_sel=0, 300 if rg_timer_sel>300, else rg_timer_sel; latched only at period start.
REQ-021 SHALL count tick_cnt 0..TICK_CYC-1 wrapping; on wrap increment per_cnt; expiry when wrap coincides with per_cnt=sel_eff-1, then per_cnt<=0 and sel_eff relatched.
REQ-022 SHALL register timer_int high exactly one cycle after each expiry; period = sel_eff*TICK_CYC cycles.
REQ-023 SHALL on expiry in WAIT enter REQ; frame_req high throughout REQ, registered.
REQ-024 SHALL in REQ on frame_ack enter RUN next cycle; frame_req low and frame_on high throughout RUN.
REQ-025 SHALL in RUN on frame_done_flag go to WAIT if rg_timer_mode=1, else IDLE; frame_on falls next cycle.
REQ-026 SHALL keep counters running in REQ/RUN in auto mode; expiry there increments miss_cnt (saturate 15) and sets timer_ovr_flag, no queued request.
REQ-027 SHALL stop counters in single mode after the first expiry.
REQ-028 SHALL on rg_timer_on=0 in WAIT or REQ go to IDLE next cycle (frame_req drops); in RUN complete the frame, then IDLE.
REQ-029 SHALL give set priority over ovr_clear when a miss and ovr_clear coincide.
REQ-030 SHALL ignore frame_ack outside REQ and frame_done_flag outside RUN.

Reset
REQ-031 SHALL on rst_n low force IDLE, all counters 0, all outputs 0, sel_eff 1, regardless of frame in progress.

Configuration
REQ-032 SHALL with FRAME_SCHED_WDT_EN defined count cycles in RUN; at WDT_CYC without frame_done_flag, set wdt_to_flag and exit as per REQ-025.
REQ-033 SHALL without FRAME_SCHED_WDT_EN remove the watchdog counter and tie wdt_to_flag to 0; port list unchanged.

Structure
REQ-034 SHALL place the state enum, TIMER_SEL_MAX=300 and default TICK_CYC/WDT_CYC in package frame_sched_pkg.
REQ-035 SHALL implement the tick/period divider as sub-module frame_sched_tick (inputs run, restart, sel_eff; output expire).

Verification (bench with TICK_CYC=4, WDT_CYC=40)
REQ-036 SHALL check auto, sel=3, ack 2 cycles after req, done 5 cycles later -> timer_int every 12 cycles, three req/ack/run cycles, miss_cnt=0.
REQ-037 SHALL check single, sel=0 -> expiry after 4 cycles, one frame, then IDLE, no further timer_int.
REQ-038 SHALL check auto, sel=1, done withheld 30 cycles -> miss_cnt=7, timer_ovr_flag=1; ovr_clear -> both 0.
REQ-039 SHALL check sel=400 -> period 1200 cycles; rg_timer_on dropped in REQ -> IDLE next cycle, frame_req=0.
REQ-040 SHALL check with FRAME_SCHED_WDT_EN, no done -> wdt_to_flag=1 after 40 RUN cycles; rst_n pulse mid-RUN -> all outputs 0.
